ov7670_config_seq: RTL and testbench

OV7670_CONFIG_SEQ -- requirements
Module: ov7670_config_seq

---
 rtl/ov7670_config_seq.sv | 149 ++++++++++++++
 tb/tb_ov7670_config_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_seq.sv
// Purpose : walks a register ROM and issues one SCCB register write per entry to bring up an OV7670.
// Latency : 3 cycles per write minimum (FETCH, DECODE, SEND); a delay entry costs DELAY_CYCLES + 2.
// Backpres: SEND holds sccb_valid/addr/data until sccb_ready; FLUSH waits for sccb_ready before done.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start                one-cycle request to run the sequence (ignored while busy)
//   rom_addr / rom_data  ROM index out, entry {reg, value} back one cycle later
//                        (16'hFFFF = end marker, 16'hFFF0 = delay marker)
//   sccb_valid/ready     write handshake; sccb_addr/sccb_data carry the register write
//   busy, done           sequence running / finished (done held until the next start)
//   error                write timed out (only when CFG_SEQ_TIMEOUT_EN is defined)
//
// Build option: define CFG_SEQ_TIMEOUT_EN to abort a write that waits TIMEOUT_CYCLES for sccb_ready.
module ov7670_config_seq #(
  parameter int DELAY_CYCLES   = 250000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sccb_valid,
  input  logic        sccb_ready,
  output logic [7:0]  sccb_addr,
  output logic [7:0]  sccb_data,
  output logic        busy,
  output logic        done
`ifdef CFG_SEQ_TIMEOUT_EN
  ,
  output logic        error
`endif
);

  // One counter serves both the delay entry and the write timeout; the two
  // are never active at the same time, so it is sized for the larger one.
  localparam int CNT_MAX = (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, SEND, DELAY, FLUSH, DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rom_addr   <= 8'd0;
      sccb_valid <= 1'b0;
      sccb_addr  <= 8'd0;
      sccb_data  <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
`ifdef CFG_SEQ_TIMEOUT_EN
      error      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= FETCH;
            rom_addr <= 8'd0;
            done     <= 1'b0;
            busy     <= 1'b1;
`ifdef CFG_SEQ_TIMEOUT_EN
            error    <= 1'b0;
`endif
          end
        end

        // The ROM is registered: the entry for rom_addr appears in DECODE.
        FETCH: state <= DECODE;

        DECODE: begin
          if (rom_data == 16'hFFFF) begin
            state <= FLUSH;
          end else if (rom_data == 16'hFFF0) begin
            cnt   <= CNT_W'(DELAY_CYCLES);
            state <= DELAY;
          end else begin
            sccb_addr  <= rom_data[15:8];
            sccb_data  <= rom_data[7:0];
            sccb_valid <= 1'b1;
            cnt        <= '0;
            state      <= SEND;
          end
        end

        // sccb_valid is always high here, so sccb_ready alone marks the transfer.
        SEND: begin
          if (sccb_ready) begin
            sccb_valid <= 1'b0;
            cnt        <= '0;
            // Entry 255 is the last possible one; the index never wraps.
            if (rom_addr == 8'hFF) begin
              state <= FLUSH;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= FETCH;
            end
          end
`ifdef CFG_SEQ_TIMEOUT_EN
          else if (cnt >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // This cycle is the TIMEOUT_CYCLES-th one spent waiting.
            sccb_valid <= 1'b0;
            error      <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end

        // Loaded with DELAY_CYCLES, leaves on the cycle it holds 1.
        DELAY: begin
          if (cnt <= CNT_W'(1)) begin
            cnt <= '0;
            if (rom_addr == 8'hFF) begin
              state <= FLUSH;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= FETCH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // sccb_ready high means the last write has left the SCCB master.
        FLUSH: begin
          if (sccb_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Self-checking bench for ov7670_config_seq: table of ROM programs with
// hand-computed results, hand sequences for handshake/restart/reset corners,
// and randomized programs checked against a simple list-walking model.
module tb_ov7670_config_seq;

  localparam int D  = 7;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_valid;
  logic        sccb_ready;
  logic [7:0]  sccb_addr;
  logic [7:0]  sccb_data;
  logic        busy;
  logic        done;
`ifdef CFG_SEQ_TIMEOUT_EN
  logic        error;
`endif

  ov7670_config_seq #(.DELAY_CYCLES(D), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_valid(sccb_valid), .sccb_ready(sccb_ready),
    .sccb_addr(sccb_addr), .sccb_data(sccb_data),
    .busy(busy), .done(done)
`ifdef CFG_SEQ_TIMEOUT_EN
    , .error(error)
`endif
  );

  always #5 clk = ~clk;

  // Registered ROM model
  logic [15:0] rom_mem [256];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Ready source: random or manual
  logic rand_ready, ready_man, rnd_bit;
  always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);
  assign sccb_ready = rand_ready ? rnd_bit : ready_man;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: log transfers, count handshake-stability and address-wrap violations
  logic [15:0] got_q [$];
  int          got_cyc [$];
  int          stab_err = 0, wrap_err = 0;
  logic        pv = 1'b0, pr = 1'b0, pb = 1'b0;
  logic [7:0]  pa = 8'd0, pd = 8'd0, pra = 8'd0;
  always @(negedge clk) begin
    if (sccb_valid && sccb_ready) begin
      got_q.push_back({sccb_addr, sccb_data});
      got_cyc.push_back(cyc_cnt);
    end
    if (pv && !pr && !(sccb_valid && sccb_addr == pa && sccb_data == pd)) stab_err++;
    if (busy && pb && rom_addr < pra) wrap_err++;
    pv = sccb_valid; pr = sccb_ready; pa = sccb_addr; pd = sccb_data;
    pb = busy; pra = rom_addr;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: walk entries in address order; writes are the non-marker
  // entries; with ready always high a write costs 3 cycles, a delay D+2,
  // the end marker 2, plus 2 for the start and flush cycles.
  logic [15:0] exp_q [$];
  int          exp_cyc;
  task automatic build_model();
    exp_q.delete();
    exp_cyc = 2;
    for (int a = 0; a < 256; a++) begin
      if (rom_mem[a] == 16'hFFFF) begin
        exp_cyc += 2;
        break;
      end else if (rom_mem[a] == 16'hFFF0) begin
        exp_cyc += D + 2;
      end else begin
        exp_q.push_back(rom_mem[a]);
        exp_cyc += 3;
      end
    end
  endtask

  task automatic cmp_writes(input string nm, input int base);
    chk({nm, "_count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
      chk(nm, 32'(got_q[base + i]), 32'(exp_q[i]));
  endtask

  task automatic wait_done(input int lim, inout int cyc);
    while (!done && cyc < lim) begin
      step();
      cyc++;
    end
    chk("done_reached", 32'(done), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  // Pulse start, optionally pulse it again at cycle restart_at, run to done.
  task automatic run_seq(input int restart_at, output int cyc);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 5000) begin
      if (cyc == restart_at) start = 1'b1;
      step();
      start = 1'b0;
      cyc++;
    end
    chk("done_reached", 32'(done), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom_mem[a] = 16'hFFFF;
  endtask

  typedef struct {
    logic [15:0] prog [6];
    int          exp_n;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_cyc;
  } vec_t;
  vec_t tbl [5];

  initial begin
    int base, cyc, s0, w0, len;
    logic [15:0] v;
    logic [7:0]  b;

    tbl[0].prog = '{16'h1280, 16'hFFF0, 16'h030A, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[0].exp_n = 2; tbl[0].exp_first = 16'h1280; tbl[0].exp_last = 16'h030A; tbl[0].exp_cyc = 12 + D;
    tbl[1].prog = '{16'hFFFF, 16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[1].exp_n = 0; tbl[1].exp_first = 16'h0; tbl[1].exp_last = 16'h0; tbl[1].exp_cyc = 4;
    tbl[2].prog = '{16'hFFF0, 16'hFFF0, 16'hFFFF, 16'h3333, 16'hFFFF, 16'hFFFF};
    tbl[2].exp_n = 0; tbl[2].exp_first = 16'h0; tbl[2].exp_last = 16'h0; tbl[2].exp_cyc = 2 * D + 8;
    tbl[3].prog = '{16'h0000, 16'hFFFE, 16'hFFF1, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[3].exp_n = 3; tbl[3].exp_first = 16'h0000; tbl[3].exp_last = 16'hFFF1; tbl[3].exp_cyc = 13;
    tbl[4].prog = '{16'hAB12, 16'hFFF0, 16'hFFF0, 16'h0102, 16'hFFFF, 16'hFFFF};
    tbl[4].exp_n = 2; tbl[4].exp_first = 16'hAB12; tbl[4].exp_last = 16'h0102; tbl[4].exp_cyc = 2 * D + 14;

    reset_n = 1'b0; start = 1'b0; ready_man = 1'b1; rand_ready = 1'b0;
    clear_rom();
    repeat (3) step();
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_sccb_valid", 32'(sccb_valid), 32'd0);
    chk("rst_sccb_addr", 32'(sccb_addr), 32'd0);
    chk("rst_sccb_data", 32'(sccb_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    repeat (5) step();
    chk("idle_no_autorun", 32'({busy, done, sccb_valid}), 32'd0);

    // Table-driven ROM programs, ready always high
    for (int i = 0; i < 5; i++) begin
      clear_rom();
      for (int j = 0; j < 6; j++) rom_mem[j] = tbl[i].prog[j];
      base = got_q.size();
      run_seq(-1, cyc);
      chk($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(tbl[i].exp_cyc));
      chk($sformatf("tbl%0d_nwrites", i), 32'(got_q.size() - base), 32'(tbl[i].exp_n));
      if (tbl[i].exp_n > 0 && got_q.size() > base) begin
        chk($sformatf("tbl%0d_first", i), 32'(got_q[base]), 32'(tbl[i].exp_first));
        chk($sformatf("tbl%0d_last", i), 32'(got_q[$]), 32'(tbl[i].exp_last));
      end
      if (i == 0 && got_cyc.size() >= base + 2)
        chk("delay_gap", 32'(got_cyc[base + 1] - got_cyc[base]), 32'(D + 5));
    end

    // Ready held low in SEND: outputs stable, exactly one transfer on release
    clear_rom();
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'h030A;
    build_model();
    ready_man = 1'b0;
    s0 = stab_err;
    base = got_q.size();
    start = 1'b1; step(); start = 1'b0;
    cyc = 0;
    while (!sccb_valid && cyc < 10) begin step(); cyc++; end
    chk("stall_valid", 32'(sccb_valid), 32'd1);
    chk("stall_addr_data", 32'({sccb_addr, sccb_data}), 32'h1280);
    repeat (20) step();
    chk("stall_stable", 32'(stab_err), 32'(s0));
    chk("stall_no_xfer", 32'(got_q.size() - base), 32'd0);
    ready_man = 1'b1;
    step();
    chk("stall_one_xfer", 32'(got_q.size() - base), 32'd1);
    chk("stall_valid_drop", 32'(sccb_valid), 32'd0);
    cyc = 0;
    wait_done(100, cyc);
    cmp_writes("stall_writes", base);

    // Start pulsed mid-sequence is ignored; start after done restarts at 0
    clear_rom();
    for (int j = 0; j < 6; j++) rom_mem[j] = tbl[0].prog[j];
    build_model();
    base = got_q.size();
    run_seq(5, cyc);
    chk("restart_ignored_cycles", 32'(cyc), 32'(12 + D));
    cmp_writes("restart_ignored", base);
    base = got_q.size();
    start = 1'b1; step(); start = 1'b0;
    chk("rerun_done_clear", 32'(done), 32'd0);
    chk("rerun_busy", 32'(busy), 32'd1);
    chk("rerun_rom_addr", 32'(rom_addr), 32'd0);
    cyc = 1;
    wait_done(5000, cyc);
    cmp_writes("rerun", base);

    // Reset mid-DELAY, then rerun from entry 0
    clear_rom();
    rom_mem[0] = 16'hFFF0; rom_mem[1] = 16'h1280;
    build_model();
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        32'({rom_addr, sccb_valid, sccb_addr, sccb_data, busy, done}), 32'd0);
    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("post_reset_idle", 32'(busy), 32'd0);
    base = got_q.size();
    run_seq(-1, cyc);
    chk("post_reset_cycles", 32'(cyc), 32'(D + 9));
    cmp_writes("post_reset", base);

    // All 256 entries are writes: no wrap, done after entry 255
    for (int a = 0; a < 256; a++) begin
      b = 8'(a);
      rom_mem[a] = {b, ~b};
    end
    build_model();
    w0 = wrap_err;
    base = got_q.size();
    run_seq(-1, cyc);
    chk("full_rom_cycles", 32'(cyc), 32'd770);
    chk("full_rom_nowrap", 32'(wrap_err), 32'(w0));
    chk("full_rom_last_addr", 32'(rom_addr), 32'hFF);
    cmp_writes("full_rom", base);

    // Randomized programs vs model; even runs use ready=1 and check timing
    for (int k = 0; k < 10; k++) begin
      clear_rom();
      len = $urandom_range(1, 20);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 4) == 0) begin
          v = 16'hFFF0;
        end else begin
          v = 16'($urandom());
          if (v == 16'hFFFF || v == 16'hFFF0) v = 16'h1234;
        end
        rom_mem[j] = v;
      end
      build_model();
      rand_ready = (k % 2 == 1);
      s0 = stab_err;
      base = got_q.size();
      run_seq(-1, cyc);
      if (!rand_ready) chk($sformatf("rand%0d_cycles", k), 32'(cyc), 32'(exp_cyc));
      chk($sformatf("rand%0d_stable", k), 32'(stab_err), 32'(s0));
      cmp_writes($sformatf("rand%0d", k), base);
      rand_ready = 1'b0;
    end

`ifdef CFG_SEQ_TIMEOUT_EN
    // Stuck ready: abort TO cycles after SEND entry
    clear_rom();
    rom_mem[0] = 16'h1280;
    ready_man = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    cyc = 0;
    while (!sccb_valid && cyc < 10) begin step(); cyc++; end
    chk("to_send_entered", 32'(sccb_valid), 32'd1);
    repeat (TO - 1) step();
    chk("to_not_yet", 32'({error, sccb_valid}), 32'b01);
    step();
    chk("to_error", 32'(error), 32'd1);
    chk("to_done", 32'(done), 32'd1);
    chk("to_valid", 32'(sccb_valid), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    ready_man = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
